// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Groups every signal that the arbiter exchanges with the core and with the memory-side decoder.
//   clk and rst_n are not carried here.
//
//   Handshake semantics, identical for the I and D core ports:
//     - The requester raises *_req and holds its address and write fields stable.
//     - The arbiter answers with a single-cycle *_ready pulse. *_rdata and *_err are valid only in that
//       cycle.
//     - On the memory side, mem_cs marks an active access and mem_* stay constant while it is high.
//     - The target completes the access by raising mem_ready for one cycle while mem_cs=1.
//
//   Modports:
//     slave  : the arbiter's view. Core requests and memory responses are inputs; core responses and
//              memory commands are outputs.
//     master : the environment's view, driving the core requests and the memory responses.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        i_err;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_err;

    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ready,
        output i_rdata, i_ready, i_err, d_rdata, d_ready, d_err,
               mem_cs, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ready,
        input  i_rdata, i_ready, i_err, d_rdata, d_ready, d_err,
               mem_cs, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one 32-bit memory-side port between the instruction-fetch port (I) and the load/store port
//   (D). Arbitration is two-way round-robin with a registered grant, so at most one transaction is in
//   flight at any time. A per-transaction timeout aborts an access whose target never answers; the
//   aborted transaction returns ERR_DATA with *_err=1.
//
//   Ports:
//     clk       : system clock, rising edge
//     rst_n     : asynchronous active-low reset
//     bus       : mem_arbiter_if.slave, carrying the core I/D ports and the memory-side port
//     dbg_state : current FSM state (0=IDLE, 1=BUSY, 2=RESP)
//
//   Parameters:
//     TIMEOUT  : maximum number of BUSY cycles before the access is aborted; 0 disables the timeout
//     ERR_DATA : read data returned on a timed-out transaction
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_arbiter_if.slave       bus,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        grant_d;   // 1 = the D port owns the current transaction
    logic        last_d;    // 1 = the most recent grant went to D
    logic [31:0] tcnt;
    logic        pick_d;
    logic        take;
    logic        tout;

    // On a tie, the port that did not win last time is served.
    assign take   = bus.i_req || bus.d_req;
    assign pick_d = bus.d_req && (!bus.i_req || !last_d);

    // tcnt counts completed BUSY cycles. The abort therefore fires in BUSY cycle number TIMEOUT.
    assign tout   = (TIMEOUT != 0) && (tcnt == TIMEOUT - 32'd1);

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = BUSY;
            BUSY:    if (bus.mem_ready || tout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_d       <= 1'b0;
            last_d        <= 1'b1;
            tcnt          <= '0;
            bus.mem_cs    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
            bus.i_rdata   <= '0;
            bus.i_ready   <= 1'b0;
            bus.i_err     <= 1'b0;
            bus.d_rdata   <= '0;
            bus.d_ready   <= 1'b0;
            bus.d_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (take) begin
                        grant_d    <= pick_d;
                        last_d     <= pick_d;
                        bus.mem_cs <= 1'b1;
                        if (pick_d) begin
                            bus.mem_we    <= bus.d_we;
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                            bus.mem_wstrb <= bus.d_wstrb;
                        end else begin
                            bus.mem_we    <= 1'b0;
                            bus.mem_addr  <= bus.i_addr;
                            bus.mem_wdata <= '0;
                            bus.mem_wstrb <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (bus.mem_ready || tout) begin
                        // A real mem_ready takes priority over a timeout in the same cycle.
                        bus.mem_cs <= 1'b0;
                        bus.mem_we <= 1'b0;
                        if (grant_d) begin
                            bus.d_ready <= 1'b1;
                            bus.d_err   <= !bus.mem_ready;
                            bus.d_rdata <= bus.mem_ready ? bus.mem_rdata : ERR_DATA;
                        end else begin
                            bus.i_ready <= 1'b1;
                            bus.i_err   <= !bus.mem_ready;
                            bus.i_rdata <= bus.mem_ready ? bus.mem_rdata : ERR_DATA;
                        end
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                RESP: begin
                    // The ready pulse ends here. rdata is left holding its captured value.
                    tcnt        <= '0;
                    bus.i_ready <= 1'b0;
                    bus.i_err   <= 1'b0;
                    bus.d_ready <= 1'b0;
                    bus.d_err   <= 1'b0;
                end
                default: begin
                    tcnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed testbench for mem_arbiter with TIMEOUT=8.
//   Inputs are driven on the falling clock edge, and outputs are checked on the falling edge.
//   A cycle runs from one rising edge to the next.
module tb_mem_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         tests_run;
    int         tests_failed;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .TIMEOUT  (8),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end, want end");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.d_wstrb   = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        tests_run++; if (bus.mem_cs !== 1'b0 || bus.mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_ctl: got cs=%b we=%b want 0 0", bus.mem_cs, bus.mem_we); end
        tests_run++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_wstrb !== 4'h0) begin tests_failed++; $display("FAIL reset_mem_bus: got %h %h %h want 0", bus.mem_addr, bus.mem_wdata, bus.mem_wstrb); end
        tests_run++; if (bus.i_ready !== 1'b0 || bus.i_err !== 1'b0 || bus.i_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_i: got %b %b %h want 0", bus.i_ready, bus.i_err, bus.i_rdata); end
        tests_run++; if (bus.d_ready !== 1'b0 || bus.d_err !== 1'b0 || bus.d_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_d: got %b %b %h want 0", bus.d_ready, bus.d_err, bus.d_rdata); end
        rst_n = 1'b1;
    endtask

    // Fetch with the target always ready: mem_cs is seen one cycle after the request and i_ready two
    // cycles after it.
    task automatic test_single_fetch();
        bus.i_req     = 1'b1;
        bus.i_addr    = 32'h10;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h12345678;
        @(negedge clk);
        tests_run++; if (bus.mem_cs !== 1'b1) begin tests_failed++; $display("FAIL fetch_cs: got %b want 1", bus.mem_cs); end
        tests_run++; if (bus.mem_addr !== 32'h10 || bus.mem_we !== 1'b0) begin tests_failed++; $display("FAIL fetch_addr: got %h we=%b want 00000010 we=0", bus.mem_addr, bus.mem_we); end
        tests_run++; if (bus.i_ready !== 1'b0) begin tests_failed++; $display("FAIL fetch_early_ready: got %b want 0", bus.i_ready); end
        @(negedge clk);
        tests_run++; if (bus.i_ready !== 1'b1 || bus.i_err !== 1'b0) begin tests_failed++; $display("FAIL fetch_ready: got rdy=%b err=%b want 1 0", bus.i_ready, bus.i_err); end
        tests_run++; if (bus.i_rdata !== 32'h12345678) begin tests_failed++; $display("FAIL fetch_rdata: got %h want 12345678", bus.i_rdata); end
        tests_run++; if (bus.d_ready !== 1'b0 || bus.mem_cs !== 1'b0) begin tests_failed++; $display("FAIL fetch_resp_side: got d_ready=%b cs=%b want 0 0", bus.d_ready, bus.mem_cs); end
        bus.i_req = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.i_ready !== 1'b0 || dbg_state !== 2'd0) begin tests_failed++; $display("FAIL fetch_pulse_end: got rdy=%b state=%0d want 0 0", bus.i_ready, dbg_state); end
        tests_run++; if (bus.i_rdata !== 32'h12345678) begin tests_failed++; $display("FAIL fetch_rdata_hold: got %h want 12345678", bus.i_rdata); end
        bus.mem_ready = 1'b0;
    endtask

    // Both ports request continuously. After reset the grants must alternate I, D, I, D.
    task automatic test_round_robin();
        logic        exp_d;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        apply_reset();
        bus.i_req     = 1'b1;
        bus.i_addr    = 32'h100;
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h200;
        bus.mem_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_d    = (t % 2) == 1;
            exp_addr = exp_d ? 32'h200 : 32'h100;
            exp_data = 32'hA0 + t;
            @(negedge clk);
            bus.mem_rdata = exp_data;
            tests_run++; if (bus.mem_cs !== 1'b1 || bus.mem_addr !== exp_addr) begin tests_failed++; $display("FAIL rr_grant%0d: got cs=%b addr=%h want 1 %h", t, bus.mem_cs, bus.mem_addr, exp_addr); end
            @(negedge clk);
            tests_run++; if (bus.i_ready !== !exp_d || bus.d_ready !== exp_d) begin tests_failed++; $display("FAIL rr_ready%0d: got i=%b d=%b want i=%b d=%b", t, bus.i_ready, bus.d_ready, !exp_d, exp_d); end
            if (exp_d) begin
                tests_run++; if (bus.d_rdata !== exp_data) begin tests_failed++; $display("FAIL rr_drdata%0d: got %h want %h", t, bus.d_rdata, exp_data); end
            end else begin
                tests_run++; if (bus.i_rdata !== exp_data) begin tests_failed++; $display("FAIL rr_irdata%0d: got %h want %h", t, bus.i_rdata, exp_data); end
            end
            @(negedge clk);
            tests_run++; if (bus.i_ready !== 1'b0 || bus.d_ready !== 1'b0 || bus.mem_cs !== 1'b0) begin tests_failed++; $display("FAIL rr_gap%0d: got i=%b d=%b cs=%b want 0 0 0", t, bus.i_ready, bus.d_ready, bus.mem_cs); end
            if (t == 3) begin
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
            end
        end
        bus.mem_ready = 1'b0;
    endtask

    // D write whose target answers in the third BUSY cycle. The command must be stable in every cycle
    // that mem_cs is high.
    task automatic test_write();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h2000_0004;
        bus.d_wstrb = 4'b0011;
        bus.d_wdata = 32'h0000A5A5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++; if (bus.mem_cs !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wstrb !== 4'b0011) begin tests_failed++; $display("FAIL wr_ctl%0d: got cs=%b we=%b strb=%b want 1 1 0011", c, bus.mem_cs, bus.mem_we, bus.mem_wstrb); end
            tests_run++; if (bus.mem_addr !== 32'h2000_0004 || bus.mem_wdata !== 32'h0000A5A5) begin tests_failed++; $display("FAIL wr_bus%0d: got %h %h want 20000004 0000a5a5", c, bus.mem_addr, bus.mem_wdata); end
            if (c == 2) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'h0BAD0BAD;
            end
        end
        @(negedge clk);
        tests_run++; if (bus.d_ready !== 1'b1 || bus.d_err !== 1'b0 || bus.i_ready !== 1'b0) begin tests_failed++; $display("FAIL wr_ready: got d=%b err=%b i=%b want 1 0 0", bus.d_ready, bus.d_err, bus.i_ready); end
        tests_run++; if (bus.mem_cs !== 1'b0 || bus.mem_we !== 1'b0) begin tests_failed++; $display("FAIL wr_resp_ctl: got cs=%b we=%b want 0 0", bus.mem_cs, bus.mem_we); end
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
    endtask

    // The target never answers. With TIMEOUT=8 the access must spend exactly 8 cycles in BUSY and then
    // complete with an error. The following request must be served normally.
    task automatic test_timeout();
        int busy_cnt;
        busy_cnt    = 0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h3000;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.d_ready === 1'b1) break;
            if (bus.mem_cs === 1'b1) busy_cnt++;
        end
        tests_run++; if (busy_cnt != 8) begin tests_failed++; $display("FAIL to_busy_cycles: got %0d want 8", busy_cnt); end
        tests_run++; if (bus.d_ready !== 1'b1 || bus.d_err !== 1'b1) begin tests_failed++; $display("FAIL to_ready_err: got rdy=%b err=%b want 1 1", bus.d_ready, bus.d_err); end
        tests_run++; if (bus.d_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL to_rdata: got %h want deadbeef", bus.d_rdata); end
        tests_run++; if (bus.i_ready !== 1'b0 || bus.i_err !== 1'b0) begin tests_failed++; $display("FAIL to_i_quiet: got %b %b want 0 0", bus.i_ready, bus.i_err); end
        bus.d_req = 1'b0;
        @(negedge clk);
        bus.d_req     = 1'b1;
        bus.d_addr    = 32'h3004;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        @(negedge clk);
        tests_run++; if (bus.d_ready !== 1'b1 || bus.d_err !== 1'b0) begin tests_failed++; $display("FAIL to_next_ready: got rdy=%b err=%b want 1 0", bus.d_ready, bus.d_err); end
        tests_run++; if (bus.d_rdata !== 32'h55AA55AA) begin tests_failed++; $display("FAIL to_next_rdata: got %h want 55aa55aa", bus.d_rdata); end
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
    endtask

    // In the first transaction the target answers late and the requester drops i_req while BUSY; the
    // access still completes. In the second transaction reset hits mid-BUSY, and no ready may follow.
    task automatic test_delay_and_reset();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h40;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++; if (bus.mem_cs !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_we !== 1'b0 || bus.mem_wstrb !== 4'h0 || bus.mem_wdata !== 32'h0) begin tests_failed++; $display("FAIL dly_bus%0d: got cs=%b addr=%h we=%b strb=%h wd=%h want 1 00000040 0 0 0", c, bus.mem_cs, bus.mem_addr, bus.mem_we, bus.mem_wstrb, bus.mem_wdata); end
            tests_run++; if (bus.i_ready !== 1'b0) begin tests_failed++; $display("FAIL dly_early%0d: got %b want 0", c, bus.i_ready); end
            if (c == 0) bus.i_req = 1'b0;
            if (c == 2) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'hCAFEF00D;
            end
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        tests_run++; if (bus.i_ready !== 1'b1 || bus.i_err !== 1'b0 || bus.i_rdata !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL dly_ready: got rdy=%b err=%b rd=%h want 1 0 cafef00d", bus.i_ready, bus.i_err, bus.i_rdata); end
        @(negedge clk);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h80;
        @(negedge clk);
        tests_run++; if (bus.mem_cs !== 1'b1 || bus.mem_addr !== 32'h80) begin tests_failed++; $display("FAIL rst_busy: got cs=%b addr=%h want 1 00000080", bus.mem_cs, bus.mem_addr); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++; if (bus.mem_cs !== 1'b0 || dbg_state !== 2'd0) begin tests_failed++; $display("FAIL rst_async: got cs=%b state=%0d want 0 0", bus.mem_cs, dbg_state); end
        tests_run++; if (bus.i_rdata !== 32'h0 || bus.mem_addr !== 32'h0) begin tests_failed++; $display("FAIL rst_clear: got rd=%h addr=%h want 0 0", bus.i_rdata, bus.mem_addr); end
        bus.i_req     = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests_run++; if (bus.i_ready !== 1'b0 || bus.d_ready !== 1'b0 || bus.mem_cs !== 1'b0) begin tests_failed++; $display("FAIL rst_no_ready%0d: got i=%b d=%b cs=%b want 0 0 0", c, bus.i_ready, bus.d_ready, bus.mem_cs); end
        end
        bus.mem_ready = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        drive_idle();
        @(negedge clk);
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_write();
        test_timeout();
        test_delay_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
